wb_fifo_deep: RTL and testbench



---
 rtl/wb_fifo_deep_pkg.sv | 12 +
 rtl/wb_fifo_deep_if.sv | 26 ++
 rtl/wb_fifo_deep_fifo_sync_mem.sv | 37 +++
 rtl/wb_fifo_deep.sv | 79 +++++++
 tb/tb_wb_fifo_deep.sv | 139 +++++++++++++
 5 files changed

// File: rtl/wb_fifo_deep_pkg.sv
// wb_fifo_deep_pkg: register word map and bit positions shared by the FIFO slave.
package wb_fifo_deep_pkg;
  typedef enum logic [1:0] {W_DATA = 2'd0, W_STATUS = 2'd1, W_CONTROL = 2'd2, W_RSVD = 2'd3} word_e;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_UNF = 3;
  localparam int ST_LEVEL_LSB = 8;
  localparam int CT_IEN = 0;
  localparam int CT_FLUSH = 1;
  localparam int CT_THRESH_LSB = 8;
endpackage

// File: rtl/wb_fifo_deep_if.sv
// wb_fifo_deep_if: Wishbone slave bus bundle with master/slave views.
interface wb_fifo_deep_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_bte_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_bte_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_fifo_deep_fifo_sync_mem.sv
// fifo_sync_mem: DEPTH-entry storage with wrap-bit pointers and asynchronous head read.
module fifo_sync_mem #(
  parameter int DW = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DW-1:0]         din,
  output logic [DW-1:0]         head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);
  logic [DW-1:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_q, rd_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (DEPTH_LOG2 + 1)'(push);
      rd_q <= rd_q + (DEPTH_LOG2 + 1)'(pop);
    end
  assign head = mem_q[rd_q[DEPTH_LOG2-1:0]];
  assign level = wr_q - rd_q;
  // level never exceeds DEPTH, so its MSB alone marks full
  assign full = level[DEPTH_LOG2];
  assign empty = level == '0;
endmodule

// File: rtl/wb_fifo_deep.sv
// wb_fifo_deep: Wishbone-mapped message FIFO with status flags and threshold interrupt.
module wb_fifo_deep
  import wb_fifo_deep_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  wb_fifo_deep_if.slave  wb,
  output logic           irq_o
);
  localparam int AL = $clog2(DW / 8);
  localparam int TW = DEPTH_LOG2 + 1;
  logic ack_q, err_q, irq_q, ovf_q, unf_q, ien_q;
  logic [DW-1:0] dat_q, rdata, head, status, control;
  logic [TW-1:0] thresh_q, level;
  logic full, empty, req, hit, acc, wr, rd, push, pop, flush;
  word_e word;
  assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign hit = wb.wb_adr_i[AW-1:AL+2] == '0;
  assign word = word_e'(wb.wb_adr_i[AL+1:AL]);
  assign acc = req & hit;
  assign wr = acc & wb.wb_we_i;
  assign rd = acc & ~wb.wb_we_i;
  assign push = wr & (word == W_DATA) & ~full;
  assign pop = rd & (word == W_DATA) & ~empty;
  assign flush = wr & (word == W_CONTROL) & wb.wb_dat_i[CT_FLUSH];
  fifo_sync_mem #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .din(wb.wb_dat_i),
    .head(head), .level(level), .full(full), .empty(empty)
  );
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf_q;
    status[ST_UNF] = unf_q;
    status[ST_LEVEL_LSB +: TW] = level;
    control = '0;
    control[CT_IEN] = ien_q;
    control[CT_THRESH_LSB +: TW] = thresh_q;
    rdata = word == W_DATA ? (empty ? '0 : head) :
            word == W_STATUS ? status :
            word == W_CONTROL ? control : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ien_q <= 1'b0;
      thresh_q <= TW'(1);
    end else begin
      ack_q <= acc;
      err_q <= req & ~hit;
      dat_q <= rd ? rdata : '0;
      irq_q <= ien_q & ((level >= thresh_q) | ovf_q);
      if (wr & (word == W_DATA) & full) ovf_q <= 1'b1;
      else if (wr & (word == W_STATUS) & wb.wb_dat_i[ST_OVF]) ovf_q <= 1'b0;
      if (rd & (word == W_DATA) & empty) unf_q <= 1'b1;
      else if (wr & (word == W_STATUS) & wb.wb_dat_i[ST_UNF]) unf_q <= 1'b0;
      if (wr & (word == W_CONTROL)) begin
        ien_q <= wb.wb_dat_i[CT_IEN];
        thresh_q <= wb.wb_dat_i[CT_THRESH_LSB +: TW];
      end
    end
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_rty_o = 1'b0;
  assign irq_o = irq_q;
  logic unused;
  assign unused = ^{wb.wb_sel_i, wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[AL-1:0]};
endmodule

// File: tb/tb_wb_fifo_deep.sv
// tb_wb_fifo_deep: directed and random bus traffic checked against a queue-based model.
module tb_wb_fifo_deep;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  bit m_ovf = 0, m_unf = 0, m_ien = 0;
  int m_thr = 1;
  wb_fifo_deep_if #(.AW(32), .DW(32)) wb ();
  wb_fifo_deep #(.AW(32), .DW(32), .DEPTH_LOG2(4)) dut (.clk(clk), .rst(rst), .wb(wb), .irq_o(irq));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic m_irq();
    return m_ien && (q.size() >= m_thr || m_ovf);
  endfunction
  function automatic logic [31:0] m_status();
    return {16'h0, 8'(q.size()), 4'h0, m_unf, m_ovf, q.size() == DEPTH, q.size() == 0};
  endfunction
  function automatic logic [31:0] m_access(input bit we, input int word, input logic [31:0] d);
    logic [31:0] r = 32'h0;
    if (word == 0 && we) begin
      if (q.size() == DEPTH) m_ovf = 1; else q.push_back(d);
    end else if (word == 0) begin
      if (q.size() == 0) m_unf = 1; else r = q.pop_front();
    end else if (word == 1 && we) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_unf = 0;
    end else if (word == 1) r = m_status();
    else if (word == 2 && we) begin
      m_ien = d[0];
      m_thr = int'(d[12:8]);
      if (d[1]) q.delete();
    end else if (word == 2) r = {19'h0, 5'(m_thr), 7'h0, m_ien};
    return r;
  endfunction
  task automatic bus(input bit we, input int word, input logic [31:0] d,
                     output logic [31:0] rdat, output bit acked, output bit erred);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = we;
    wb.wb_adr_i = 32'(word * 4); wb.wb_dat_i = d; wb.wb_sel_i = 4'hf;
    acked = 0; erred = 0; rdat = 0;
    for (int i = 0; i < 8 && !(acked || erred); i++) begin
      @(posedge clk); #1;
      acked = wb.wb_ack_o; erred = wb.wb_err_o; rdat = wb.wb_dat_o;
    end
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0;
    if (!(acked || erred)) check("response_timeout", 0, 1);
  endtask
  task automatic op(input bit we, input int word, input logic [31:0] d);
    logic [31:0] r, e;
    bit a, er;
    logic old_irq;
    old_irq = m_irq();
    bus(we, word, d, r, a, er);
    e = m_access(we, word, d);
    check($sformatf("ack w%0d", word), 32'(a), 32'(word < 4));
    check($sformatf("err w%0d", word), 32'(er), 32'(word >= 4));
    if (!we && word < 4) check($sformatf("rdata w%0d", word), r, e);
    check("irq_at_ack", 32'(irq), 32'(old_irq));
    @(posedge clk); #1;
    check("irq_after", 32'(irq), 32'(m_irq()));
    check("resp_pulse", 32'(wb.wb_ack_o | wb.wb_err_o), 0);
  endtask
  initial begin
    logic [31:0] d;
    int w;
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0; wb.wb_adr_i = 0;
    wb.wb_dat_i = 0; wb.wb_sel_i = 0; wb.wb_cti_i = 0; wb.wb_bte_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_ack", 32'(wb.wb_ack_o), 0);
    check("rst_err", 32'(wb.wb_err_o), 0);
    check("rst_dat", wb.wb_dat_o, 0);
    check("rst_irq", 32'(irq), 0);
    check("rty", 32'(wb.wb_rty_o), 0);
    op(0, 1, 0);
    check("rst_status", m_status(), 32'h1);
    op(0, 2, 0);
    op(1, 0, 32'h11); op(1, 0, 32'h22); op(1, 0, 32'h33);
    repeat (3) op(0, 0, 0);
    op(0, 1, 0);
    for (int i = 0; i < 17; i++) op(1, 0, $urandom);
    op(0, 1, 0);
    check("full_status_model", m_status(), 32'h1006);
    repeat (16) op(0, 0, 0);
    op(1, 1, 32'h4);
    op(0, 1, 0);
    op(0, 0, 0);
    op(0, 1, 0);
    op(1, 1, 32'h8);
    for (int i = 0; i < 40; i++) begin
      op(1, 0, $urandom);
      op(0, 0, 0);
    end
    op(1, 2, 32'h301);
    repeat (3) op(1, 0, $urandom);
    op(0, 0, 0);
    op(1, 2, 32'h303);
    op(0, 1, 0);
    op(0, 5, 0);
    op(1, 5, 32'hffff_ffff);
    op(0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(7))
        0, 1, 2: w = 0;
        3, 4: w = 1;
        5: w = 2;
        6: w = 3;
        default: w = 5;
      endcase
      d = $urandom;
      if ($urandom_range(7) != 0) d[1] = 0;
      op(1'($urandom_range(1)), w, d);
    end
    op(1, 0, 32'hA5); op(1, 0, 32'h5A);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 0; wb.wb_adr_i = 32'h4;
    #2 rst = 1;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(wb.wb_ack_o), 0);
    check("rst_mid_err", 32'(wb.wb_err_o), 0);
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0;
    rst = 0;
    q.delete(); m_ovf = 0; m_unf = 0; m_ien = 0; m_thr = 1;
    op(0, 1, 0);
    op(0, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
